// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the MiniUart receiver. Holds the
//               receive FSM state encodings, the state register width and
//               the default values for the receiver parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receive FSM state encoding
    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START     = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA      = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_PARITY    = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_STOP      = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_IDLE = 3'd5;

    // Default receiver configuration
    localparam int c_DATA_BITS_DEF  = 8;
    localparam int c_OVERSAMPLE_DEF = 16;
    localparam int c_FIFO_DEPTH_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Small synchronous FIFO for received words with a
//               first-word fall-through head output. Pointers carry one
//               extra wrap bit so full and empty can be told apart.
//               A push into a full FIFO is accepted only when a pop
//               happens in the same cycle; a pop of an empty FIFO is ignored.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset
//               i_push   - write i_wdata
//               i_wdata  - word to write
//               i_pop    - discard head entry
//               o_rdata  - head entry (0 while empty)
//               o_full   - FIFO holds DEPTH entries
//               o_empty  - FIFO holds no entries
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A simultaneous pop frees the slot the push needs
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised MiniUart receiver. Synchronises rxd, recovers
//               frames using an oversampled tick (en_rx), and stores the
//               received words in an RX FIFO with fall-through head.
//               Sticky framing, parity and overrun flags are cleared by
//               err_clr. Fully synchronous datapath, no derived clocks.
// Config      : UART_RX_PARITY_EN - when defined, a parity bit follows the
//               data bits (parity_odd selects odd/even) and perr is live.
//               When undefined, frames are start+data+stop and perr is 0.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               en_rx      - sample tick, OVERSAMPLE x baud, one clk wide
//               rxd        - serial input, idle high
//               parity_odd - 1 = odd parity, 0 = even parity
//               rd_en      - pop FIFO head
//               err_clr    - clear fe / perr / overrun
//               d_out      - FIFO head word
//               rx_valid   - FIFO non-empty
//               fe         - sticky framing error
//               perr       - sticky parity error
//               overrun    - sticky overrun
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = c_DATA_BITS_DEF,
    parameter int OVERSAMPLE = c_OVERSAMPLE_DEF,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_rx,
    input  logic                 rxd,
    input  logic                 parity_odd,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_valid,
    output logic                 fe,
    output logic                 perr,
    output logic                 overrun
);

    localparam int c_CW  = $clog2(OVERSAMPLE);
    localparam int c_BCW = $clog2(DATA_BITS);

    localparam logic [c_CW-1:0]  c_CNT_HALF = c_CW'(OVERSAMPLE/2 - 1);
    localparam logic [c_CW-1:0]  c_CNT_FULL = c_CW'(OVERSAMPLE - 1);
    localparam logic [c_BCW-1:0] c_BIT_LAST = c_BCW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_rxd_meta;
    logic r_rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers and control
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_CW-1:0]      r_cnt;
    logic [c_BCW-1:0]     r_bitcnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_push;
    logic                 r_fe;
    logic                 r_overrun;

    logic w_sample;
    logic w_cnt_half;
    logic w_cnt_full;
    logic w_cnt_dec;
    logic w_shift;
    logic w_bit_clr;
    logic w_push_req;
    logic w_fe_set;
    logic w_ovr_set;
    logic w_fifo_full;
    logic w_fifo_empty;

    assign w_sample = en_rx && (r_cnt == '0);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (en_rx && !r_rxd_s) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_sample) begin
                    // Line back high at mid start bit: treat as a glitch
                    w_state_nxt = r_rxd_s ? c_ST_IDLE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_sample && (r_bitcnt == c_BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = c_ST_PARITY;
`else
                    w_state_nxt = c_ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_sample) begin
                    w_state_nxt = c_ST_STOP;
                end
            end
`endif
            c_ST_STOP: begin
                if (w_sample) begin
                    w_state_nxt = r_rxd_s ? c_ST_IDLE : c_ST_WAIT_IDLE;
                end
            end
            c_ST_WAIT_IDLE: begin
                if (en_rx && r_rxd_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM: output / control decode
    always_comb begin
        w_cnt_half = 1'b0;
        w_cnt_full = 1'b0;
        w_cnt_dec  = 1'b0;
        w_shift    = 1'b0;
        w_bit_clr  = 1'b0;
        w_push_req = 1'b0;
        w_fe_set   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // First sample lands half a bit later, in mid start bit
                w_cnt_half = en_rx && !r_rxd_s;
                w_bit_clr  = en_rx && !r_rxd_s;
            end
            c_ST_START, c_ST_DATA, c_ST_PARITY, c_ST_STOP: begin
                w_cnt_full = w_sample;
                w_cnt_dec  = en_rx && !w_sample;
                if (r_state == c_ST_DATA) begin
                    w_shift = w_sample;
                end
                if (r_state == c_ST_STOP) begin
                    w_push_req = w_sample && r_rxd_s;
                    w_fe_set   = w_sample && !r_rxd_s;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_push   <= 1'b0;
        end else begin
            r_push <= w_push_req;

            if (w_cnt_half) begin
                r_cnt <= c_CNT_HALF;
            end else if (w_cnt_full) begin
                r_cnt <= c_CNT_FULL;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - c_CW'(1);
            end

            if (w_bit_clr) begin
                r_bitcnt <= '0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + c_BCW'(1);
            end

            // LSB first: new bits enter at the top and move down
            if (w_shift) begin
                r_shreg <= {r_rxd_s, r_shreg[DATA_BITS-1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags. A set in the same cycle as err_clr wins.
    // ------------------------------------------------------------------
    assign w_ovr_set = r_push && w_fifo_full && !rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fe      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_fe      <= w_fe_set  | (r_fe      & ~err_clr);
            r_overrun <= w_ovr_set | (r_overrun & ~err_clr);
        end
    end

    assign fe      = r_fe;
    assign overrun = r_overrun;

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic w_perr_set;

    // Data plus parity bit must XOR to the selected parity sense
    assign w_perr_set = (r_state == c_ST_PARITY) && w_sample &&
                        ((^r_shreg ^ r_rxd_s) != parity_odd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_set | (r_perr & ~err_clr);
        end
    end

    assign perr = r_perr;
`else
    logic w_unused_parity_odd;

    assign w_unused_parity_odd = parity_odd;
    assign perr                = 1'b0;
`endif

    // ------------------------------------------------------------------
    // RX FIFO. The shift register is stable in the cycle after the stop
    // sample, so it feeds the registered push directly.
    // ------------------------------------------------------------------
    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_wdata (r_shreg),
        .i_pop   (rd_en),
        .o_rdata (d_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rx_valid = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed self-checking bench for uart_rx_param
//               (DATA_BITS=8, OVERSAMPLE=16, FIFO_DEPTH=4). en_rx is a
//               one-clk tick every second clock; one bit lasts 16 ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en_rx;
    logic                 rxd;
    logic                 parity_odd;
    logic                 rd_en;
    logic                 err_clr;
    logic [DATA_BITS-1:0] d_out;
    logic                 rx_valid;
    logic                 fe;
    logic                 perr;
    logic                 overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_rx      (en_rx),
        .rxd        (rxd),
        .parity_odd (parity_odd),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .d_out      (d_out),
        .rx_valid   (rx_valid),
        .fe         (fe),
        .perr       (perr),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One en_rx tick (2 clocks); optional rd_en in the tick cycle
    task automatic tick(input logic rd);
        en_rx = 1'b1;
        rd_en = rd;
        @(posedge clk); #1;
        en_rx = 1'b0;
        rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (OVERSAMPLE) tick(1'b0);
    endtask

    task automatic send_head(input logic [DATA_BITS-1:0] d);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) begin
            send_bit(d[i]);
        end
    endtask

    // Whole frame; stop-bit sample falls on tick 9 of the bit
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop,
                              input logic rd_at_stop);
        send_head(d);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ parity_odd);
`endif
        rxd = stop;
        for (int i = 0; i < OVERSAMPLE; i++) begin
            tick(rd_at_stop && (i == 9));
        end
    endtask

    task automatic pop_chk(input string tag, input logic [DATA_BITS-1:0] exp);
        chk(tag, d_out, exp);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic clr_errors();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        en_rx      = 1'b0;
        rxd        = 1'b1;
        parity_odd = 1'b0;
        rd_en      = 1'b0;
        err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_d_out",    d_out,    0);
        chk("rst_fe",       fe,       0);
        chk("rst_perr",     perr,     0);
        chk("rst_overrun",  overrun,  0);
        rst = 1'b0;
        repeat (4) tick(1'b0);

        // Frame 0x55: rx_valid rises exactly one clk after the stop sample
        send_head(8'h55);
`ifdef UART_RX_PARITY_EN
        send_bit(^8'h55);
`endif
        rxd = 1'b1;
        repeat (9) tick(1'b0);
        chk("t1_before_stop", rx_valid, 0);
        en_rx = 1'b1;
        @(posedge clk); #1;
        chk("t1_at_stop_edge", rx_valid, 0);
        en_rx = 1'b0;
        @(posedge clk); #1;
        chk("t1_one_clk_after", rx_valid, 1);
        repeat (6) tick(1'b0);
        pop_chk("t1_d_out", 8'h55);
        chk("t1_empty_after_pop", rx_valid, 0);

        // Start glitch: low for 4 ticks only
        rxd = 1'b0;
        repeat (4) tick(1'b0);
        rxd = 1'b1;
        repeat (24) tick(1'b0);
        chk("t2_no_push", rx_valid, 0);
        chk("t2_fe",      fe,       0);
        chk("t2_perr",    perr,     0);
        chk("t2_overrun", overrun,  0);

        // Framing error then clean frame
        send_frame(8'hA3, 1'b0, 1'b0);
        chk("t3_fe_set",   fe,       1);
        chk("t3_no_push",  rx_valid, 0);
        send_bit(1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("t3_valid",    rx_valid, 1);
        chk("t3_fe_stays", fe,       1);
        clr_errors();
        chk("t3_fe_clr",   fe,       0);
        pop_chk("t3_d_out", 8'h3C);

        // Overrun: five frames, no reads
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1'b0);
        end
        chk("t4_overrun", overrun, 1);
        pop_chk("t4_pop0", 8'h01);
        pop_chk("t4_pop1", 8'h02);
        pop_chk("t4_pop2", 8'h03);
        pop_chk("t4_pop3", 8'h04);
        chk("t4_empty", rx_valid, 0);
        clr_errors();
        chk("t4_ovr_clr", overrun, 0);

        // Full FIFO with a read in the stop-sample cycle
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b1, 1'b0);
        end
        chk("t5_full_no_ovr", overrun, 0);
        send_frame(8'h05, 1'b1, 1'b1);
        chk("t5_ovr_stays0", overrun, 0);
        pop_chk("t5_pop0", 8'h02);
        pop_chk("t5_pop1", 8'h03);
        pop_chk("t5_pop2", 8'h04);
        pop_chk("t5_pop3", 8'h05);
        chk("t5_empty", rx_valid, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity, 0x07 has three ones: parity bit 0 is wrong
        parity_odd = 1'b0;
        send_head(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t6_perr_set", perr, 1);
        pop_chk("t6_d_out_bad", 8'h07);
        clr_errors();
        send_head(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t6_perr_ok", perr, 0);
        pop_chk("t6_d_out_ok", 8'h07);
        // Odd parity, same data, parity bit 0 is correct
        parity_odd = 1'b1;
        send_head(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t6_odd_ok", perr, 0);
        pop_chk("t6_d_out_odd", 8'h07);
        parity_odd = 1'b0;
`else
        parity_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        chk("t6_perr_tied", perr, 0);
        pop_chk("t6_d_out", 8'h07);
        parity_odd = 1'b0;
`endif

        // Reset in the middle of DATA with state to clear
        send_frame(8'h66, 1'b1, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0);
        send_bit(1'b1);
        chk("t7_pre_valid", rx_valid, 1);
        chk("t7_pre_fe",    fe,       1);
        send_bit(1'b0);
        send_bit(1'b1);
        rxd = 1'b0;
        repeat (5) tick(1'b0);
        rst = 1'b1;
        #2;
        chk("t7_rst_valid",   rx_valid, 0);
        chk("t7_rst_d_out",   d_out,    0);
        chk("t7_rst_fe",      fe,       0);
        chk("t7_rst_perr",    perr,     0);
        chk("t7_rst_overrun", overrun,  0);
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick(1'b0);
        send_frame(8'h9E, 1'b1, 1'b0);
        chk("t7_valid", rx_valid, 1);
        chk("t7_fe",    fe,       0);
        pop_chk("t7_d_out", 8'h9E);
        chk("t7_empty", rx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
